// File: rtl/pmem_line_bridge.sv
// pmem_line_bridge: turns 128-bit line reads/writes from the L2 cache into
// eight 16-bit beats on a narrow memory bus, lowest word first.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a line request; captures address and write data
// S_READ  | issuing read beats, filling rbuf word by word
// S_WRITE | issuing write beats out of the captured write buffer
// S_RESP  | one-cycle completion strobe back to the cache
module pmem_line_bridge (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read_i,
  input  logic         pmem_write_i,
  input  logic [15:0]  pmem_address_i,
  input  logic [127:0] pmem_wdata_i,
  output logic [127:0] pmem_rdata_o,
  output logic         pmem_resp_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [15:0]  mem_addr_o,
  output logic [15:0]  mem_wdata_o,
  input  logic [15:0]  mem_rdata_i,
  input  logic         mem_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         state_q;
  logic [2:0]     beat_q;
  logic [11:0]    line_addr_q;
  logic [127:0]   wbuf_q;
  logic [127:0]   rbuf_q;
  logic           mem_req_q;
  logic           mem_we_q;
  logic           pmem_resp_q;

  // Byte-within-line bits are don't-care; the beat counter supplies them.
  logic unused_addr_bits;
  assign unused_addr_bits = ^pmem_address_i[3:0];

  // Sequencer: accepts a request, walks beats 0..7, then pulses resp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      beat_q      <= 3'd0;
      line_addr_q <= 12'd0;
      wbuf_q      <= 128'd0;
      rbuf_q      <= 128'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      pmem_resp_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pmem_resp_q <= 1'b0;
          // Write wins when both requests are raised together.
          if (pmem_write_i || pmem_read_i) begin
            state_q     <= pmem_write_i ? S_WRITE : S_READ;
            line_addr_q <= pmem_address_i[15:4];
            wbuf_q      <= pmem_wdata_i;
            beat_q      <= 3'd0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= pmem_write_i;
          end
        end
        S_READ, S_WRITE: begin
          if (mem_ready_i) begin
            if (state_q == S_READ) begin
              rbuf_q[{beat_q, 4'b0000} +: 16] <= mem_rdata_i;
            end
            beat_q <= beat_q + 3'd1;
            if (beat_q == 3'd7) begin
              state_q     <= S_RESP;
              mem_req_q   <= 1'b0;
              mem_we_q    <= 1'b0;
              pmem_resp_q <= 1'b1;
            end
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          pmem_resp_q <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          mem_req_q   <= 1'b0;
          mem_we_q    <= 1'b0;
          pmem_resp_q <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_rdata_o = rbuf_q;
  assign pmem_resp_o  = pmem_resp_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = {line_addr_q, beat_q, 1'b0};
  assign mem_wdata_o  = wbuf_q[{beat_q, 4'b0000} +: 16];

endmodule

// File: tb/tb_pmem_line_bridge.sv
// Bench for pmem_line_bridge: directed scenarios plus randomized line
// transactions, checked against a word-array memory model.
module tb_pmem_line_bridge;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pmem_read_i;
  logic         pmem_write_i;
  logic [15:0]  pmem_address_i;
  logic [127:0] pmem_wdata_i;
  logic [127:0] pmem_rdata_o;
  logic         pmem_resp_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [15:0]  mem_addr_o;
  logic [15:0]  mem_wdata_o;
  logic [15:0]  mem_rdata_i;
  logic         mem_ready_i;

  always #5 clk = ~clk;

  pmem_line_bridge dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pmem_read_i    (pmem_read_i),
    .pmem_write_i   (pmem_write_i),
    .pmem_address_i (pmem_address_i),
    .pmem_wdata_i   (pmem_wdata_i),
    .pmem_rdata_o   (pmem_rdata_o),
    .pmem_resp_o    (pmem_resp_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .mem_ready_i    (mem_ready_i)
  );

  logic [15:0]  mem [0:32767];
  logic [127:0] exp_rbuf;
  int           n_pass  = 0;
  int           n_total = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] line_of(input logic [15:0] a);
    logic [127:0] l;
    for (int k = 0; k < 8; k++) l[16*k +: 16] = mem[{a[15:4], 3'(k)}];
    return l;
  endfunction

  function automatic int pick_stall(input int fixed);
    return (fixed >= 0) ? fixed : int'($urandom_range(0, 2));
  endfunction

  // One complete line transaction; fixed_stall < 0 means random stalls per beat.
  task automatic run_txn(input bit is_wr, input bit both, input logic [15:0] addr,
                         input logic [127:0] wdata, input int fixed_stall);
    int k, w, s, sum, lat;
    logic [15:0] base;
    base = {addr[15:4], 4'h0};
    k = 0; w = 0; lat = 0;
    s = pick_stall(fixed_stall);
    sum = s;
    pmem_read_i    = !is_wr || both;
    pmem_write_i   = is_wr;
    pmem_address_i = addr;
    pmem_wdata_i   = wdata;
    for (int c = 0; c < 300; c++) begin
      if (mem_req_o) mem_ready_i = (w >= s);
      else           mem_ready_i = 1'($urandom);
      mem_rdata_i = mem[mem_addr_o[15:1]];
      if (mem_req_o) begin
        if (k < 8) begin
          chk("beat_addr", mem_addr_o, base + 16'(2*k));
          chk("beat_we", mem_we_o, is_wr);
          if (is_wr) chk("beat_wdata", mem_wdata_o, wdata[16*k +: 16]);
        end else begin
          chk("extra_beat", mem_req_o, 1'b0);
        end
        if (mem_ready_i) begin
          if (is_wr && k < 8) mem[{base[15:4], 3'(k)}] = wdata[16*k +: 16];
          k++;
          w = 0;
          if (k < 8) begin
            s = pick_stall(fixed_stall);
            sum += s;
          end
        end else begin
          w++;
        end
      end
      tick();
      lat++;
      if (c == 0) begin
        pmem_address_i = 16'hFFFF;
        pmem_wdata_i   = ~wdata;
      end
      if (pmem_resp_o) break;
    end
    chk("resp_seen", pmem_resp_o, 1'b1);
    chk("latency", lat, 9 + sum);
    chk("beat_count", k, 8);
    if (!is_wr) exp_rbuf = line_of(base);
    chk("rdata", pmem_rdata_o, exp_rbuf);
    pmem_read_i  = 1'b0;
    pmem_write_i = 1'b0;
    tick();
    chk("resp_one_cycle", pmem_resp_o, 1'b0);
    chk("idle_no_req", mem_req_o, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_resp"},  pmem_resp_o,  1'b0);
    chk({tag, "_rdata"}, pmem_rdata_o, 128'd0);
    chk({tag, "_req"},   mem_req_o,    1'b0);
    chk({tag, "_we"},    mem_we_o,     1'b0);
    chk({tag, "_addr"},  mem_addr_o,   16'd0);
    chk({tag, "_wdata"}, mem_wdata_o,  16'd0);
  endtask

  initial begin
    logic [127:0] wd;
    logic         seen;
    rst_n = 1'b0;
    pmem_read_i = 1'b0; pmem_write_i = 1'b0;
    pmem_address_i = 16'd0; pmem_wdata_i = 128'd0;
    mem_rdata_i = 16'd0; mem_ready_i = 1'b0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    for (int k = 0; k < 8; k++) mem[(16'h1230 >> 1) + k] = 16'hA000 + 16'(k);

    tick(); tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    exp_rbuf = 128'd0;

    // Basic read with known memory contents.
    run_txn(1'b0, 1'b0, 16'h1234, 128'd0, 0);
    chk("read_1234_line", pmem_rdata_o, 128'hA007_A006_A005_A004_A003_A002_A001_A000);

    // Writeback; read buffer must not change.
    run_txn(1'b1, 1'b0, 16'h00F0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0);
    chk("write_keeps_rdata", pmem_rdata_o, 128'hA007_A006_A005_A004_A003_A002_A001_A000);

    // Three stall cycles before every beat.
    run_txn(1'b0, 1'b0, 16'h5670, 128'd0, 3);

    // Read and write together: write wins, followed immediately by a read-back.
    wd = {$urandom, $urandom, $urandom, $urandom};
    run_txn(1'b1, 1'b1, 16'h0300, wd, 0);
    run_txn(1'b0, 1'b0, 16'h0308, 128'd0, 0);
    chk("readback_line", pmem_rdata_o, wd);

    // Randomized mix of reads, writes, stalls and addresses.
    for (int t = 0; t < 12; t++) begin
      run_txn(1'($urandom), 1'($urandom), 16'($urandom),
              {$urandom, $urandom, $urandom, $urandom}, -1);
    end

    // Reset during beat 4 of a read.
    pmem_read_i = 1'b1; pmem_address_i = 16'h2000; mem_ready_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      mem_rdata_i = mem[mem_addr_o[15:1]];
      if (mem_req_o && mem_addr_o == 16'h2008) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("reached_beat4", seen, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    pmem_read_i = 1'b0;
    tick();
    chk("midreset_no_resp", pmem_resp_o, 1'b0);
    tick();
    rst_n = 1'b1;
    exp_rbuf = 128'd0;
    tick();
    chk("post_reset_no_resp", pmem_resp_o, 1'b0);
    run_txn(1'b0, 1'b0, 16'h4000, 128'd0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pmem_line_bridge.md
PMEM_LINE_BRIDGE -- requirements
Module: pmem_line_bridge

Interface
REQ-001 The block SHALL have no parameters: line fixed at 128 bits (lc3b_data), narrow bus fixed at 16 bits (lc3b_word), 8 beats per line.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 pmem_read  in  1  line-read request from L2 cache, level-held until pmem_resp.
REQ-005 pmem_write  in  1  line-write (writeback) request from L2 cache, level-held until pmem_resp.
REQ-006 pmem_address  in  16  byte address of line; bits [3:0] ignored.
REQ-007 pmem_wdata  in  128  line to write.
REQ-008 pmem_rdata  out  128  assembled read line.
REQ-009 pmem_resp  out  1  one-cycle completion strobe to cache.
REQ-010 mem_req  out  1  narrow-bus beat request.
REQ-011 mem_we  out  1  1 = write beat, 0 = read beat; valid while mem_req=1.
REQ-012 mem_addr  out  16  word-aligned beat byte address.
REQ-013 mem_wdata  out  16  write beat data.
REQ-014 mem_rdata  in  16  read beat data, valid when mem_ready=1.
REQ-015 mem_ready  in  1  beat completes on any edge where mem_req=1 and mem_ready=1.

Function
REQ-016 FSM states SHALL be IDLE, READ, WRITE, RESP; 3-bit beat counter beat[2:0].
REQ-017 IDLE: mem_req=0, pmem_resp=0; on pmem_write=1 go to WRITE, else on pmem_read=1 go to READ (write wins if both high); capture line_addr=pmem_address[15:4], wbuf=pmem_wdata, beat=0.
REQ-018 While READ/WRITE, pmem_address, pmem_wdata, pmem_read, pmem_write SHALL be ignored; captured values used.
REQ-019 READ/WRITE: mem_req=1, mem_we=(state==WRITE), mem_addr={line_addr, beat, 1'b0}, mem_wdata=wbuf[16*beat+15 : 16*beat].
REQ-020 On completed read beat, rbuf[16*beat+15 : 16*beat] SHALL load mem_rdata; other rbuf words unchanged.
REQ-021 On completed beat with beat<7, beat SHALL increment; with beat==7, go to RESP, beat wraps to 0.
REQ-022 mem_ready=0 in READ/WRITE SHALL stall with all outputs held, unbounded wait.
REQ-023 mem_ready while mem_req=0 SHALL be ignored.
REQ-024 RESP: pmem_resp=1 for exactly one cycle, mem_req=0, then IDLE unconditionally.
REQ-025 pmem_rdata SHALL equal rbuf at all times; rbuf holds until overwritten beat-by-beat by a later read; writes never modify rbuf.
REQ-026 Minimum latency with mem_ready tied 1: request seen in IDLE at cycle 0, beats cycles 1-8, pmem_resp cycle 9; next request accepted cycle 10.
REQ-027 Beats SHALL issue in ascending order 0..7, word 0 = bits [15:0] at byte offset 0.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, beat=0, line_addr=0, wbuf=0, rbuf=0; outputs pmem_resp=0, pmem_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-029 Reset mid-transaction SHALL abandon it with no pmem_resp; first request after rst_n rises is accepted normally.

Verification
REQ-030 Read, mem_ready=1, pmem_address=16'h1234, memory word at 16'h1230+2k = 16'hA000+k -> mem_addr 1230,1232,...,123E cycles 1-8; pmem_resp cycle 9; pmem_rdata=128'hA007_A006_..._A000.
REQ-031 Write, pmem_address=16'h00F0, pmem_wdata=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 -> beats mem_we=1, addr 00F0..00FE, data 3210,7654,BA98,FEDC,CDEF,89AB,4567,0123; pmem_resp once; pmem_rdata unchanged.
REQ-032 Read with mem_ready low 3 cycles before each beat -> 32 beat cycles, mem_addr held during stall, pmem_resp cycle 33, data correct.
REQ-033 pmem_read and pmem_write both 1 in IDLE -> WRITE performed; pmem_address changed to 16'hFFFF during beats 2-5 -> mem_addr unaffected.
REQ-034 Writeback then immediate read (cache changes request in cycle after pmem_resp) -> second transaction starts next IDLE cycle, two distinct pmem_resp pulses, no beat lost.
REQ-035 rst_n low during beat 4 of read -> all outputs 0 same cycle, no pmem_resp; subsequent read of 16'h4000 completes with correct line.
